// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: register map, control/status bit layout
// and the controller FSM encoding.
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_PERIODIC  = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int CTRL_W         = 3;
  localparam int STATUS_EXPIRED = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Field order puts en at bit 0, so a raw write-data slice casts straight into this.
  typedef struct packed {
    logic irq_en;
    logic periodic;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the interval timer: counts 0..PRESCALE-1 while enabled and pulses
// o_tick on the wrap cycle; a synchronous clear parks it at zero.
module timer_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;
  logic          w_wrap;

  assign w_wrap = (r_pre == LAST);

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (i_clear) begin
      r_pre <= '0;
    end else if (i_enable) begin
      r_pre <= w_wrap ? '0 : r_pre + PW'(1);
    end
  end

  assign o_tick = i_enable && !i_clear && w_wrap;

endmodule

// File: rtl/timer_ctrl.sv
// Programmable interval timer: CPU register file, load/run/reload sequencing of the
// down-counter, expiry tick, sticky status and level interrupt request.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int CNT_W    = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [1:0]       addr,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] rdata,
  output logic             rd_valid,
  input  logic             irq_ack,
  output logic             irq,
  output logic             tick_out,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_reload;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_rdata;
  logic             r_expired;
  logic             r_irq;
  logic             r_tick;
  logic             r_rd_valid;

  ctrl_t            w_ctrl_wdata;
  logic             w_ctrl_wr;
  logic             w_stop;
  logic             w_status_clr;
  logic             w_pre_clear;
  logic             w_pre_tick;
  logic             w_expire;
  logic [CNT_W-1:0] w_rd_mux;

  assign w_ctrl_wdata = ctrl_t'(wdata[CTRL_W-1:0]);
  assign w_ctrl_wr    = wr_en && (addr == ADDR_CTRL);
  assign w_stop       = w_ctrl_wr && !w_ctrl_wdata.en;
  assign w_status_clr = wr_en && (addr == ADDR_STATUS) && wdata[STATUS_EXPIRED];

  // A stop request beats a coincident expiry: the prescaler is cleared, so no tick.
  assign w_pre_clear = (r_state != ST_RUN) || w_stop;
  assign w_expire    = (r_state == ST_RUN) && w_pre_tick && (r_count == CNT_W'(1));

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .i_clear  (w_pre_clear),
    .i_enable (r_state == ST_RUN),
    .o_tick   (w_pre_tick)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps this combinational block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_ctrl_wr && w_ctrl_wdata.en) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = w_stop ? ST_IDLE : ST_RUN;
      ST_RUN:  if (w_stop || (w_expire && !r_ctrl.periodic)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl   <= '0;
      r_reload <= '0;
    end else begin
      if (w_ctrl_wr) r_ctrl <= w_ctrl_wdata;
      if (w_expire && !r_ctrl.periodic) r_ctrl.en <= 1'b0;
      if (wr_en && (addr == ADDR_RELOAD)) r_reload <= wdata;
    end
  end

  // Count 0 decrements to all-ones, which is how RELOAD=0 yields a 2^CNT_W period.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if ((r_state == ST_LOAD) && !w_stop) begin
      r_count <= r_reload;
    end else if (w_pre_tick) begin
      if (r_count == CNT_W'(1)) r_count <= r_ctrl.periodic ? r_reload : '0;
      else                      r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_expired <= 1'b0;
      r_irq     <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= w_expire;
      if (w_expire)          r_expired <= 1'b1;
      else if (w_status_clr) r_expired <= 1'b0;
      if (w_expire && r_ctrl.irq_en)     r_irq <= 1'b1;
      else if (irq_ack || w_status_clr)  r_irq <= 1'b0;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (addr)
      ADDR_CTRL:   w_rd_mux = CNT_W'(r_ctrl);
      ADDR_RELOAD: w_rd_mux = r_reload;
      ADDR_COUNT:  w_rd_mux = r_count;
      ADDR_STATUS: w_rd_mux = CNT_W'(r_expired);
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rdata <= w_rd_mux;
    end
  end

  assign rdata    = r_rdata;
  assign rd_valid = r_rd_valid;
  assign irq      = r_irq;
  assign tick_out = r_tick;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: a PRESCALE=4 instance for directed and randomized runs against
// an arithmetic timing model, plus a PRESCALE=1 instance for per-cycle and 2^16 periods.
module tb_timer_ctrl;
  import timer_pkg::*;

  localparam int P_A = 4;

  logic        clk;
  logic        rst_n;
  logic        wr_en    [2];
  logic        rd_en    [2];
  logic        irq_ack  [2];
  logic [1:0]  addr     [2];
  logic [15:0] wdata    [2];
  logic [15:0] rdata    [2];
  logic        rd_valid [2];
  logic        irq      [2];
  logic        tick_out [2];
  logic        busy     [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tq0[$];
  int tq1[$];
  int exp_q[$];

  timer_ctrl #(.PRESCALE(P_A), .CNT_W(16)) u_dut_a (
    .clk_in(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .rd_valid(rd_valid[0]), .irq_ack(irq_ack[0]),
    .irq(irq[0]), .tick_out(tick_out[0]), .busy(busy[0])
  );

  timer_ctrl #(.PRESCALE(1), .CNT_W(16)) u_dut_b (
    .clk_in(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .rd_valid(rd_valid[1]), .irq_ack(irq_ack[1]),
    .irq(irq[1]), .tick_out(tick_out[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc seen at a falling edge is the index of the rising edge just before it.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tick_out[0]) tq0.push_back(cyc);
    if (tick_out[1]) tq1.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // COUNT after rising edge t when en=1 was written at edge e0: one load edge, then
  // one decrement per p edges, counting down from r (0 meaning 65536).
  function automatic int model_count(input int r, input int p, input bit per,
                                     input int e0, input int t);
    longint full;
    longint wraps;
    full  = (r == 0) ? 65536 : r;
    wraps = (t - e0 - 1) / p;
    if (per)               return int'((full - (wraps % full)) % 65536);
    else if (wraps >= full) return 0;
    else                   return int'((full - wraps) % 65536);
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic bus_write(input int u, input logic [1:0] a, input logic [15:0] d);
    wr_en[u] = 1'b1; addr[u] = a; wdata[u] = d;
    @(negedge clk);
    wr_en[u] = 1'b0;
  endtask

  task automatic bus_read(input int u, input logic [1:0] a, output logic [15:0] d);
    rd_en[u] = 1'b1; addr[u] = a;
    @(negedge clk);
    rd_en[u] = 1'b0;
    check("rd_valid", rd_valid[u], 1);
    d = rdata[u];
  endtask

  task automatic pulse_ack(input int u);
    irq_ack[u] = 1'b1;
    @(negedge clk);
    irq_ack[u] = 1'b0;
  endtask

  task automatic check_ticks(input string tag, input int u);
    int got[$];
    if (u == 0) got = tq0;
    else        got = tq1;
    check({tag, "_num"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(tag, got[i], exp_q[i]);
    exp_q.delete();
    if (u == 0) tq0.delete();
    else        tq1.delete();
  endtask

  task automatic quiesce(input int u);
    bus_write(u, ADDR_CTRL, 16'd0);
    bus_write(u, ADDR_STATUS, 16'd1);
    pulse_ack(u);
    repeat (2) @(negedge clk);
    if (u == 0) tq0.delete();
    else        tq1.delete();
  endtask

  initial begin
    logic [15:0] d;
    int e0, ew, k, win, r, nt;
    bit per, ie;

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      wr_en[u] = 1'b0; rd_en[u] = 1'b0; irq_ack[u] = 1'b0; addr[u] = 2'd0; wdata[u] = 16'd0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_rdata", rdata[u], 0);
      check("rst_rd_valid", rd_valid[u], 0);
      check("rst_irq", irq[u], 0);
      check("rst_tick", tick_out[u], 0);
      check("rst_busy", busy[u], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      bus_read(0, 2'(a), d);
      check("rst_reg", d, 0);
    end

    // One-shot, RELOAD=3: single tick 13 edges after the enabling write.
    bus_write(0, ADDR_RELOAD, 16'd3);
    bus_write(0, ADDR_CTRL, 16'b001);
    e0 = cyc;
    wait_until(e0 + 20);
    exp_q.push_back(e0 + 13);
    check_ticks("t1_tick", 0);
    check("t1_busy", busy[0], 0);
    check("t1_irq", irq[0], 0);
    bus_read(0, ADDR_CTRL, d);   check("t1_ctrl", d, 0);
    bus_read(0, ADDR_STATUS, d); check("t1_status", d, 1);
    bus_read(0, ADDR_COUNT, d);  check("t1_count", d, 0);
    quiesce(0);

    // Periodic with irq, RELOAD=2: ticks every 8, ack clears, next expiry re-raises.
    bus_write(0, ADDR_RELOAD, 16'd2);
    bus_write(0, ADDR_CTRL, 16'b111);
    e0 = cyc;
    wait_until(e0 + 9);
    check("t2_tick1", tick_out[0], 1);
    check("t2_irq_set", irq[0], 1);
    pulse_ack(0);
    check("t2_irq_ack", irq[0], 0);
    wait_until(e0 + 17);
    check("t2_irq_reset", irq[0], 1);
    wait_until(e0 + 26);
    bus_write(0, ADDR_CTRL, 16'd0);
    wait_until(e0 + 40);
    for (int j = 1; j <= 3; j++) exp_q.push_back(e0 + 1 + 8 * j);
    check_ticks("t2_tick", 0);
    quiesce(0);

    // Same-cycle read and write of RELOAD returns the old value.
    wr_en[0] = 1'b1; rd_en[0] = 1'b1; addr[0] = ADDR_RELOAD; wdata[0] = 16'd9;
    @(negedge clk);
    wr_en[0] = 1'b0; rd_en[0] = 1'b0;
    check("rw_prewrite", rdata[0], 2);
    bus_read(0, ADDR_RELOAD, d); check("rw_postwrite", d, 9);

    // Periodic stop at a random point: COUNT freezes, no later ticks.
    bus_write(0, ADDR_RELOAD, 16'd3);
    bus_write(0, ADDR_CTRL, 16'b011);
    e0 = cyc;
    wait_until(e0 + 3 + int'($urandom_range(0, 20)));
    bus_write(0, ADDR_CTRL, 16'd0);
    ew = cyc;
    check("t3_busy", busy[0], 0);
    bus_read(0, ADDR_COUNT, d); check("t3_count", d, model_count(3, P_A, 1'b1, e0, ew - 1));
    repeat (20) @(negedge clk);
    bus_read(0, ADDR_COUNT, d); check("t3_count_held", d, model_count(3, P_A, 1'b1, e0, ew - 1));
    for (int j = 1; e0 + 1 + 12 * j < ew; j++) exp_q.push_back(e0 + 1 + 12 * j);
    check_ticks("t3_tick", 0);
    quiesce(0);

    // RELOAD rewritten mid-period: current period 20, then 4.
    bus_write(0, ADDR_RELOAD, 16'd5);
    bus_write(0, ADDR_CTRL, 16'b011);
    e0 = cyc;
    wait_until(e0 + 7);
    bus_write(0, ADDR_RELOAD, 16'd1);
    wait_until(e0 + 31);
    bus_write(0, ADDR_CTRL, 16'd0);
    wait_until(e0 + 40);
    exp_q.push_back(e0 + 21); exp_q.push_back(e0 + 25); exp_q.push_back(e0 + 29);
    check_ticks("t4_tick", 0);
    quiesce(0);

    // Expiry coincident with STATUS W1C and irq_ack: the set wins.
    bus_write(0, ADDR_RELOAD, 16'd1);
    bus_write(0, ADDR_CTRL, 16'b101);
    e0 = cyc;
    wait_until(e0 + 4);
    wr_en[0] = 1'b1; addr[0] = ADDR_STATUS; wdata[0] = 16'd1; irq_ack[0] = 1'b1;
    @(negedge clk);
    wr_en[0] = 1'b0; irq_ack[0] = 1'b0;
    check("t5_tick", tick_out[0], 1);
    check("t5_irq", irq[0], 1);
    bus_read(0, ADDR_STATUS, d); check("t5_status", d, 1);
    quiesce(0);

    // Randomized runs against the timing model.
    for (int it = 0; it < 10; it++) begin
      r   = int'($urandom_range(1, 6));
      per = 1'($urandom_range(0, 1));
      ie  = 1'($urandom_range(0, 1));
      bus_write(0, ADDR_RELOAD, 16'(r));
      bus_write(0, ADDR_CTRL, {13'd0, ie, per, 1'b1});
      e0  = cyc;
      win = int'($urandom_range(3, r * P_A * 3));
      k   = e0 + 1 + int'($urandom_range(0, win - 3));
      wait_until(k);
      bus_read(0, ADDR_COUNT, d);
      check("rnd_count", d, model_count(r, P_A, per, e0, k));
      wait_until(e0 + win);
      nt = 0;
      for (int j = 1; e0 + 1 + r * P_A * j <= e0 + win; j++) begin
        if (!per && j > 1) break;
        exp_q.push_back(e0 + 1 + r * P_A * j);
        nt++;
      end
      check("rnd_irq", irq[0], (ie && nt > 0) ? 1 : 0);
      check("rnd_busy", busy[0], (per || nt == 0) ? 1 : 0);
      bus_write(0, ADDR_CTRL, 16'd0);
      check_ticks("rnd_tick", 0);
      bus_read(0, ADDR_STATUS, d); check("rnd_status", d, (nt > 0) ? 1 : 0);
      quiesce(0);
    end

    // Reset asserted mid-run, at a cycle where tick, irq and rd_valid are all high.
    bus_write(0, ADDR_RELOAD, 16'd1);
    bus_write(0, ADDR_CTRL, 16'b111);
    e0 = cyc;
    wait_until(e0 + 8);
    bus_read(0, ADDR_RELOAD, d);
    check("t6_pre_tick", tick_out[0], 1);
    check("t6_pre_irq", irq[0], 1);
    check("t6_pre_rdata", d, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rdata", rdata[0], 0);
    check("t6_rd_valid", rd_valid[0], 0);
    check("t6_irq", irq[0], 0);
    check("t6_tick", tick_out[0], 0);
    check("t6_busy", busy[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    tq0.delete();
    bus_read(0, ADDR_CTRL, d);   check("t6_ctrl", d, 0);
    bus_read(0, ADDR_RELOAD, d); check("t6_reload", d, 0);

    // PRESCALE=1, RELOAD=1 periodic: a tick every RUN cycle.
    bus_write(1, ADDR_RELOAD, 16'd1);
    bus_write(1, ADDR_CTRL, 16'b011);
    e0 = cyc;
    wait_until(e0 + 6);
    bus_write(1, ADDR_CTRL, 16'd0);
    repeat (3) @(negedge clk);
    for (int j = 2; j <= 6; j++) exp_q.push_back(e0 + j);
    check_ticks("p1_tick", 1);
    quiesce(1);

    // PRESCALE=1, RELOAD=0 one-shot: 65536-cycle countdown starting from a wrap to 0xFFFF.
    bus_write(1, ADDR_RELOAD, 16'd0);
    bus_write(1, ADDR_CTRL, 16'b001);
    e0 = cyc;
    wait_until(e0 + 2);
    bus_read(1, ADDR_COUNT, d);
    check("p1_count_wrap", d, model_count(0, 1, 1'b0, e0, e0 + 2));
    wait_until(e0 + 65536 + 4);
    exp_q.push_back(e0 + 1 + 65536);
    check_ticks("p1_tick65536", 1);
    check("p1_busy", busy[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
